// File: rtl/calc_pkg.sv
// calc_pkg: shared types and constants for the calculator operand sequencer.
//   state_e      : sequencer FSM encoding (IDLE/EXEC/DONE, 2-bit)
//   OP_ADD/OP_SUB: op codes sampled on the Go edge; OP_SUB also drives carry-in
//   W_DEF        : default datapath width (must match the external adder)
//   CNT_W_DEF    : default width of the completed-operation counter
package calc_pkg;
   localparam int W_DEF     = 11;
   localparam int CNT_W_DEF = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/calc_operand_sequencer_if.sv
// calc_operand_sequencer_if: button/switch inputs, adder loop-back and status
// outputs of the operand sequencer.
//   master : environment side (switches, buttons, external adder result)
//   slave  : sequencer side (drives adder operands and status)
interface calc_operand_sequencer_if #(
   parameter int W     = 11,
   parameter int CNT_W = 8
);
   logic [W-1:0]     Din;
   logic             Load;
   logic             Go;
   logic             Op;
   logic             Clear;
   logic [W-1:0]     S_in;
   logic             ovf_in;
   logic [W-1:0]     A_out;
   logic [W-1:0]     B_out;
   logic             c0_out;
   logic [W-1:0]     Result;
   logic             Ovf;
   logic             Busy;
   logic             Done;
   logic [CNT_W-1:0] OpCount;

   modport master (
      output Din, Load, Go, Op, Clear, S_in, ovf_in,
      input  A_out, B_out, c0_out, Result, Ovf, Busy, Done, OpCount
   );

   modport slave (
      input  Din, Load, Go, Op, Clear, S_in, ovf_in,
      output A_out, B_out, c0_out, Result, Ovf, Busy, Done, OpCount
   );
endinterface

// File: rtl/calc_operand_sequencer_rise_edge.sv
// rise_edge: single-flop rising-edge detector for a debounced level button.
//   clk, rst : clock, synchronous active-high reset (history cleared)
//   d        : button level
//   rise     : high for the one cycle where d = 1 and history = 0
module rise_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic rise
);
   logic hist_q, hist_d;

   always_comb hist_d = d;

   always_ff @(posedge clk) begin
      if (rst) hist_q <= 1'b0;
      else     hist_q <= hist_d;
   end

   assign rise = d & ~hist_q;
endmodule

// File: rtl/calc_operand_sequencer.sv
// calc_operand_sequencer: front end of the calculator datapath. Latches the
// switch operand, sequences one add/subtract per Go press through the external
// W-bit adder and commits the sum into a running accumulator.
//   Clock, Reset : clock, synchronous active-high reset
//   bus (slave)  : Din/Load/Go/Op/Clear buttons, S_in/ovf_in from the adder,
//                  A_out/B_out/c0_out to the adder, Result/Ovf/Busy/Done/OpCount
// Build option: define CALC_SATURATE_EN to clamp the accumulator to max
// positive / most negative on an overflowing commit instead of wrapping.
module calc_operand_sequencer
   import calc_pkg::*;
#(
   parameter int W     = W_DEF,
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic Clock,
   input  logic Reset,
   calc_operand_sequencer_if.slave bus
);
   state_e           state_q, state_d;
   logic [W-1:0]     acc_q, acc_d;
   logic [W-1:0]     opnd_q, opnd_d;
   logic             op_q, op_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             load_e, go_e, clear_e;
   logic [W-1:0]     commit_val;

   rise_edge u_load  (.clk(Clock), .rst(Reset), .d(bus.Load),  .rise(load_e));
   rise_edge u_go    (.clk(Clock), .rst(Reset), .d(bus.Go),    .rise(go_e));
   rise_edge u_clear (.clk(Clock), .rst(Reset), .d(bus.Clear), .rise(clear_e));

`ifdef CALC_SATURATE_EN
   // Clamp direction follows the accumulator sign before the commit.
   always_comb begin
      commit_val = bus.S_in;
      if (bus.ovf_in)
         commit_val = acc_q[W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   end
`else
   always_comb commit_val = bus.S_in;
`endif

   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      opnd_d  = opnd_q;
      op_d    = op_q;
      ovf_d   = ovf_q;
      cnt_d   = cnt_q;
      if (clear_e) begin
         // Clear overrides everything, aborting an in-flight EXEC without commit.
         acc_d   = '0;
         ovf_d   = 1'b0;
         cnt_d   = '0;
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE: begin
               // Load and Go together: EXEC sees the freshly loaded operand.
               if (load_e) opnd_d = bus.Din;
               if (go_e) begin
                  op_d    = bus.Op;
                  state_d = EXEC;
               end
            end
            EXEC: begin
               acc_d   = commit_val;
               ovf_d   = ovf_q | bus.ovf_in;
               cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
               state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q <= IDLE;
         acc_q   <= '0;
         opnd_q  <= '0;
         op_q    <= OP_ADD;
         ovf_q   <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         opnd_q  <= opnd_d;
         op_q    <= op_d;
         ovf_q   <= ovf_d;
         cnt_q   <= cnt_d;
      end
   end

   assign bus.A_out   = acc_q;
   assign bus.B_out   = opnd_q;
   assign bus.c0_out  = op_q;
   assign bus.Result  = acc_q;
   assign bus.Ovf     = ovf_q;
   assign bus.Busy    = (state_q != IDLE);
   assign bus.Done    = (state_q == DONE);
   assign bus.OpCount = cnt_q;
endmodule

// File: tb/tb_calc_operand_sequencer.sv
module tb_calc_operand_sequencer;
   localparam int W = 11;
   localparam int CNT_W = 8;

   logic Clock = 1'b0;
   logic Reset;
   int   total = 0;
   int   bad   = 0;

   calc_operand_sequencer_if #(.W(W), .CNT_W(CNT_W)) bus ();

   calc_operand_sequencer #(.W(W), .CNT_W(CNT_W)) dut (
      .Clock(Clock),
      .Reset(Reset),
      .bus  (bus.slave)
   );

   // External ripple add/subtract stage: S = A + (B ^ {W{c0}}) + c0.
   logic [W-1:0] b_eff;
   assign b_eff      = bus.c0_out ? ~bus.B_out : bus.B_out;
   assign bus.S_in   = bus.A_out + b_eff + {{(W-1){1'b0}}, bus.c0_out};
   assign bus.ovf_in = (bus.A_out[W-1] == b_eff[W-1]) && (bus.S_in[W-1] != bus.A_out[W-1]);

   always #5 Clock = ~Clock;

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic load(input logic [W-1:0] v);
      bus.Din  = v;
      bus.Load = 1'b1;
      tick();
      bus.Load = 1'b0;
      tick();
   endtask

   task automatic clear();
      bus.Clear = 1'b1;
      tick();
      bus.Clear = 1'b0;
      tick();
   endtask

   // Go edge, then check Done is high exactly one cycle after the EXEC cycle.
   task automatic run_op(input logic op, input string tag);
      bus.Op = op;
      bus.Go = 1'b1;
      tick();
      bus.Go = 1'b0;
      tick();
      chk({tag, "_done_hi"}, bus.Done, 1);
      tick();
      chk({tag, "_done_lo"}, {bus.Done, bus.Busy}, 0);
   endtask

   initial begin
      Reset = 1'b1;
      bus.Din = '0; bus.Load = 0; bus.Go = 0; bus.Op = 0; bus.Clear = 0;
      tick(); tick();
      Reset = 1'b0;
      chk("rst_result", bus.Result, 0);
      chk("rst_ovf", bus.Ovf, 0);
      chk("rst_cnt", bus.OpCount, 0);
      chk("rst_busy_done", {bus.Busy, bus.Done}, 0);
      chk("rst_ab_c0", {bus.A_out, bus.B_out, bus.c0_out}, 0);

      // 0 + 5
      load(11'd5);
      chk("load5_b", bus.B_out, 5);
      bus.Op = 1'b0; bus.Go = 1'b1;
      tick();
      chk("add5_exec_busy", {bus.Busy, bus.Done}, 2'b10);
      chk("add5_exec_ab", {bus.A_out, bus.B_out, bus.c0_out}, {11'd0, 11'd5, 1'b0});
      bus.Go = 1'b0;
      tick();
      chk("add5_done", bus.Done, 1);
      chk("add5_result", bus.Result, 5);
      chk("add5_cnt", bus.OpCount, 1);
      tick();
      chk("add5_done_pulse", bus.Done, 0);

      // 5 - 3
      load(11'd3);
      bus.Op = 1'b1; bus.Go = 1'b1;
      tick();
      chk("sub3_exec", {bus.A_out, bus.B_out, bus.c0_out}, {11'd5, 11'd3, 1'b1});
      bus.Go = 1'b0;
      tick();
      chk("sub3_done", bus.Done, 1);
      chk("sub3_result", bus.Result, 2);
      chk("sub3_ovf", bus.Ovf, 0);
      tick();

      // Overflow at the positive limit
      clear();
      load(11'd1023);
      run_op(1'b0, "to1023");
      chk("acc1023", bus.Result, 11'h3FF);
      load(11'd1);
      run_op(1'b0, "ovf_add");
      chk("ovf_set", bus.Ovf, 1);
`ifdef CALC_SATURATE_EN
      chk("ovf_result", bus.Result, 11'h3FF);
`else
      chk("ovf_result", bus.Result, 11'h400);
`endif
      load(11'd0);
      run_op(1'b0, "add0");
      chk("ovf_sticky", bus.Ovf, 1);
      chk("ovf_cnt", bus.OpCount, 3);

      // Clear edge resets accumulator state
      clear();
      chk("clr_state", {bus.Result, bus.Ovf, bus.OpCount}, 0);

      // Held Go, re-press during Busy, Load during Busy
      load(11'd2);
      bus.Op = 1'b0; bus.Go = 1'b1;
      tick();
      bus.Go = 1'b0; bus.Din = 11'd9; bus.Load = 1'b1;
      tick();
      chk("held_done", bus.Done, 1);
      bus.Go = 1'b1; bus.Load = 1'b0;
      for (int i = 0; i < 20; i++) tick();
      bus.Go = 1'b0;
      tick();
      chk("held_cnt", bus.OpCount, 1);
      chk("held_result", bus.Result, 2);
      chk("busy_load_ignored", bus.B_out, 2);
      chk("held_idle", {bus.Busy, bus.Done}, 0);

      // Clear during EXEC aborts
      bus.Op = 1'b1; bus.Go = 1'b1;
      tick();
      chk("abort_exec", bus.Busy, 1);
      bus.Go = 1'b0; bus.Clear = 1'b1;
      tick();
      chk("abort_no_done", {bus.Busy, bus.Done}, 0);
      chk("abort_state", {bus.Result, bus.Ovf, bus.OpCount}, 0);
      bus.Clear = 1'b0;
      tick();
      chk("abort_still_no_done", bus.Done, 0);
      chk("abort_keep_opnd_op", {bus.B_out, bus.c0_out}, {11'd2, 1'b1});

      // Load and Go in the same cycle, then counter wrap
      bus.Din = 11'd7; bus.Load = 1'b1; bus.Op = 1'b0; bus.Go = 1'b1;
      tick();
      bus.Load = 1'b0; bus.Go = 1'b0;
      chk("lg_exec_b", bus.B_out, 7);
      tick();
      chk("lg_done", bus.Done, 1);
      chk("lg_result", bus.Result, 7);
      tick();
      for (int i = 0; i < 255; i++) begin
         bus.Go = 1'b1;
         tick();
         bus.Go = 1'b0;
         tick(); tick();
      end
      chk("wrap_cnt", bus.OpCount, 0);
      chk("wrap_ovf", bus.Ovf, 1);
`ifdef CALC_SATURATE_EN
      chk("wrap_result", bus.Result, 11'h3FF);
`else
      chk("wrap_result", bus.Result, 11'h700);
`endif

      // Reset mid-operation
      bus.Go = 1'b1;
      tick();
      chk("rst_mid_exec", bus.Busy, 1);
      bus.Go = 1'b0; Reset = 1'b1;
      tick();
      Reset = 1'b0;
      chk("rst_mid_no_done", {bus.Busy, bus.Done}, 0);
      chk("rst_mid_state", {bus.Result, bus.B_out, bus.Ovf, bus.OpCount}, 0);
      tick();
      chk("rst_mid_after", bus.Done, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
